// File: rtl/i2c_master_core.sv
// i2c_master_core
// Single-shot I2C write master for a 100 MHz system clock. After reset it
// sends START, one address byte, one data byte and STOP on an open-drain SDA
// line, then parks the bus in DONE until the next reset.
//
// Bus timing: a 25-cycle phase (250 ns), four phases per 1 us bit slot.
//   phases 0-1 : scl low    phases 2-3 : scl high
// SDA is changed at the start of phase 0 (START and STOP excepted, since
// those conditions are defined by SDA moving while SCL is high).
//
// Build option: define I2C_NACK_ABORT_EN to make a NACK on the address byte
// skip the data byte and go straight to STOP. Without the macro the address
// acknowledge is not used and the data byte is always sent.
module i2c_master_core (
  input  logic       clk100mhz,
  input  logic       res,
  input  logic [7:0] addr_to_send,
  input  logic [7:0] data_to_send,
  inout  wire        sda,
  output logic       scl,
  output logic       clk2mhz_dummy
);

  localparam logic [4:0] CYC_LAST = 5'd24;

  localparam logic [2:0] ST_START    = 3'd0;
  localparam logic [2:0] ST_ADDR     = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK = 3'd2;
  localparam logic [2:0] ST_DATA     = 3'd3;
  localparam logic [2:0] ST_DATA_ACK = 3'd4;
  localparam logic [2:0] ST_STOP     = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;

  logic [4:0] cyc_cnt;
  logic [1:0] phase;
  logic [2:0] state;
  logic [2:0] state_next;
  logic [2:0] bit_idx;
  logic [7:0] addr_q;
  logic [7:0] data_q;
  logic       sda_low;
  logic       phase_end;
  logic       slot_end;
  logic       latch_now;

  assign phase_end = (cyc_cnt == CYC_LAST);
  assign slot_end  = phase_end && (phase == 2'd3);

  // The very first edge out of reset is the only edge that sees START with a
  // zero counter, which makes it the natural point to capture the payload.
  assign latch_now = (state == ST_START) && (phase == 2'd0) && (cyc_cnt == 5'd0);

  // Phase timebase: 25-cycle phases, a 2-bit phase index inside each bit
  // slot, and the 2 MHz observation clock that flips on every phase wrap.
  always_ff @(posedge clk100mhz) begin
    if (res) begin
      cyc_cnt       <= 5'd0;
      phase         <= 2'd0;
      clk2mhz_dummy <= 1'b0;
    end else if (phase_end) begin
      cyc_cnt       <= 5'd0;
      phase         <= phase + 2'd1;
      clk2mhz_dummy <= ~clk2mhz_dummy;
    end else begin
      cyc_cnt <= cyc_cnt + 5'd1;
    end
  end

  // Capture the address and data bytes once per transaction so that later
  // changes on the inputs cannot corrupt a byte that is half shifted out.
  always_ff @(posedge clk100mhz) begin
    if (!res && latch_now) begin
      addr_q <= addr_to_send;
      data_q <= data_to_send;
    end
  end

`ifdef I2C_NACK_ABORT_EN
  logic addr_nack;

  // Sample the slave's address acknowledge on the last cycle of phase 2,
  // well inside the SCL-high window. Anything other than a clean 0 (high,
  // floating or unknown) is treated as NACK.
  always_ff @(posedge clk100mhz) begin
    if (res) begin
      addr_nack <= 1'b1;
    end else if ((state == ST_ADDR_ACK) && phase_end && (phase == 2'd2)) begin
      if (sda == 1'b0) begin
        addr_nack <= 1'b0;
      end else begin
        addr_nack <= 1'b1;
      end
    end
  end
`endif

  // Transaction sequencing: every state change happens at a bit-slot
  // boundary; the byte states stay put until their last bit has gone out.
  always_comb begin
    state_next = state;
    if (slot_end) begin
      case (state)
        ST_START: state_next = ST_ADDR;
        ST_ADDR: begin
          if (bit_idx == 3'd0) begin
            state_next = ST_ADDR_ACK;
          end
        end
        ST_ADDR_ACK: begin
`ifdef I2C_NACK_ABORT_EN
          if (addr_nack) begin
            state_next = ST_STOP;
          end else begin
            state_next = ST_DATA;
          end
`else
          state_next = ST_DATA;
`endif
        end
        ST_DATA: begin
          if (bit_idx == 3'd0) begin
            state_next = ST_DATA_ACK;
          end
        end
        ST_DATA_ACK: state_next = ST_STOP;
        ST_STOP:     state_next = ST_DONE;
        default:     state_next = ST_DONE;
      endcase
    end
  end

  // State register and bit pointer. The pointer counts 7 down to 0 during a
  // byte and wraps back to 7 after the last bit, so it is already aligned
  // for the data byte when the address byte finishes.
  always_ff @(posedge clk100mhz) begin
    if (res) begin
      state   <= ST_START;
      bit_idx <= 3'd7;
    end else begin
      state <= state_next;
      if (slot_end && ((state == ST_ADDR) || (state == ST_DATA))) begin
        bit_idx <= bit_idx - 3'd1;
      end
    end
  end

  // Bus drive decode: SCL follows phase[1] inside clocked slots and idles
  // high otherwise; SDA is only ever pulled low, a 1 bit is left to the
  // external pull-up.
  always_comb begin
    scl     = 1'b1;
    sda_low = 1'b0;
    case (state)
      ST_START: begin
        sda_low = phase[1];
      end
      ST_ADDR: begin
        scl     = phase[1];
        sda_low = ~addr_q[bit_idx];
      end
      ST_ADDR_ACK, ST_DATA_ACK: begin
        scl = phase[1];
      end
      ST_DATA: begin
        scl     = phase[1];
        sda_low = ~data_q[bit_idx];
      end
      ST_STOP: begin
        scl     = phase[1];
        sda_low = (phase != 2'd3);
      end
      default: begin
        scl     = 1'b1;
        sda_low = 1'b0;
      end
    endcase
  end

  assign sda = sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_core.sv
// tb_i2c_master_core
// Drives reset/payload into i2c_master_core, plays a simple slave that can
// pull SDA low in chosen windows, and compares scl, sda and clk2mhz_dummy in
// the middle of every phase against a slot/phase model of the I2C write.
// Time inside a transaction is counted in clock edges k since the first
// edge with reset low: slot = k/100, phase = (k/25)%4.
`timescale 1ns/1ps
module tb_i2c_master_core;

  localparam int BIG = 1000000;

`ifdef I2C_NACK_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  logic       clk100mhz = 1'b0;
  logic       res = 1'b1;
  logic [7:0] addr_to_send = 8'h00;
  logic [7:0] data_to_send = 8'h00;
  logic       scl;
  logic       clk2mhz_dummy;
  logic       slave_low = 1'b0;
  wire        sda;

  int checks = 0;
  int passes = 0;
  int lo1 = BIG;
  int hi1 = BIG;
  int lo2 = BIG;
  int hi2 = BIG;

  // Board pull-up plus an open-drain slave
  pullup (sda);
  assign sda = slave_low ? 1'b0 : 1'bz;

  i2c_master_core dut (
    .clk100mhz     (clk100mhz),
    .res           (res),
    .addr_to_send  (addr_to_send),
    .data_to_send  (data_to_send),
    .sda           (sda),
    .scl           (scl),
    .clk2mhz_dummy (clk2mhz_dummy)
  );

  // 100 MHz system clock
  always #5 clk100mhz = ~clk100mhz;

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] d, input logic r);
    addr_to_send = a;
    data_to_send = d;
    res          = r;
  endtask

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s: observed %b expected %b at %0t", tag, observed, expected, $time);
  endtask

  function automatic bit slaveLowAt(input int k);
    return ((k >= lo1) && (k < hi1)) || ((k >= lo2) && (k < hi2));
  endfunction

  // Expected bus behaviour from the slot/phase schedule of a write
  function automatic void modelBus(input int k, input logic [7:0] a, input logic [7:0] d,
                                   input bit nack, output logic sclE, output logic lowE);
    int s;
    int p;
    s = k / 100;
    p = (k / 25) % 4;
    if (ABORT_EN && nack && (s >= 10)) s = s + 9;
    sclE = 1'b1;
    lowE = 1'b0;
    if (s == 0) begin
      lowE = (p >= 2);
    end else if (s <= 8) begin
      sclE = (p >= 2);
      lowE = !a[8 - s];
    end else if (s == 9) begin
      sclE = (p >= 2);
    end else if (s <= 17) begin
      sclE = (p >= 2);
      lowE = !d[17 - s];
    end else if (s == 18) begin
      sclE = (p >= 2);
    end else if (s == 19) begin
      sclE = (p >= 2);
      lowE = (p != 3);
    end
  endfunction

  task automatic runTransaction(input string name, input logic [7:0] a, input logic [7:0] d,
                                input int resetCycles, input int resetAt, input int lastK);
    logic sclE;
    logic lowE;
    logic sdaE;
    logic clkE;
    bit   nack;
    res       = 1'b1;
    slave_low = 1'b0;
    repeat (resetCycles) @(negedge clk100mhz);
    #1;
    checkOutput({name, "_rst_scl"}, scl, 1'b1);
    checkOutput({name, "_rst_sda"}, sda, 1'b1);
    checkOutput({name, "_rst_clk2"}, clk2mhz_dummy, 1'b0);
    nack = !slaveLowAt(974);
    applyStimulus(a, d, 1'b0);
    for (int k = 1; k <= lastK; k++) begin
      @(negedge clk100mhz);
      slave_low = slaveLowAt(k);
      if (k == 300) applyStimulus(8'($urandom_range(255)), 8'($urandom_range(255)), 1'b0);
      #1;
      if ((k % 25) == 12) begin
        modelBus(k, a, d, nack, sclE, lowE);
        sdaE = !(lowE || slave_low);
        clkE = (((k / 25) % 2) == 1);
        checkOutput($sformatf("%s_k%0d_scl", name, k), scl, sclE);
        checkOutput($sformatf("%s_k%0d_sda", name, k), sda, sdaE);
        checkOutput($sformatf("%s_k%0d_clk2", name, k), clk2mhz_dummy, clkE);
      end
      if (k == resetAt) begin
        res       = 1'b1;
        slave_low = 1'b0;
        @(negedge clk100mhz);
        #1;
        checkOutput({name, "_midrst_scl"}, scl, 1'b1);
        checkOutput({name, "_midrst_sda"}, sda, 1'b1);
        checkOutput({name, "_midrst_clk2"}, clk2mhz_dummy, 1'b0);
        break;
      end
    end
  endtask

  // Directed sequence of transactions with randomized payloads
  initial begin
    logic [7:0] a;
    logic [7:0] d;
    $display("[TB] start");

    // Reference write 0x99/0x55, slave pulls low around the address ACK and
    // holds SDA low from mid data byte through STOP and DONE
    lo1 = 750;  hi1 = 1050; lo2 = 1550; hi2 = BIG;
    runTransaction("ref", 8'h99, 8'h55, 4, 0, 2300);

    // Random payload, slave ACKs both bytes
    a = 8'($urandom_range(255));
    d = 8'($urandom_range(255));
    lo1 = 900;  hi1 = 1000; lo2 = 1800; hi2 = 1900;
    runTransaction("ack", a, d, 4, 0, 2300);

    // Random payload, nobody acknowledges
    a = 8'($urandom_range(255));
    d = 8'($urandom_range(255));
    lo1 = BIG;  hi1 = BIG;  lo2 = BIG;  hi2 = BIG;
    runTransaction("nack", a, d, 4, 0, 2300);

    // Reset pulse of 3 cycles in the middle of the address byte, then a
    // complete transaction with a fresh payload
    a = 8'($urandom_range(255));
    d = 8'($urandom_range(255));
    lo1 = 900;  hi1 = 1000; lo2 = 1800; hi2 = 1900;
    runTransaction("abort", a, d, 4, 500, 2300);
    a = 8'($urandom_range(255));
    d = 8'($urandom_range(255));
    runTransaction("restart", a, d, 2, 0, 2300);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
